hex_scroll_ctrl: RTL and testbench

Scrolling-message controller for the six-digit seven-segment display bank (HEX5..HEX0) on the DE0-CV board. It holds a message of up to DEPTH segment patterns, written by the board top or a host FSM. It sequences a window of six consecutive characters across the display at a programmable rate, with start, stop, pause and single-step control. It replaces fixed, key-selected word assignments to the HEX outputs.

---
 rtl/hex_scroll_ctrl.sv | 177 +++++++++++++++++
 tb/tb_hex_scroll_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hex_scroll_ctrl
// Purpose  : Scrolling-message controller for the six-digit seven-segment
//            bank (HEX5..HEX0). Holds a message of up to DEPTH segment
//            patterns and slides a six-character window across the digits
//            at a programmable rate, with start/stop/pause/single-step.
// Ports    : CLOCK_50, RESET_N        - clock, async active-low reset
//            wr_en/wr_addr/wr_data    - message buffer write port
//            len_we/len_in            - message length load (saturates)
//            start/stop/step (pulses), pause (level)
//            hex5..hex0               - registered digit patterns
//            running, wrap            - registered status
// Revision : 1.0 - initial release
// ============================================================================
module hex_scroll_ctrl #(
  parameter int                DEPTH     = 16,
  parameter int                SEG_W     = 7,
  parameter int                TICK_DIV  = 12500000,
  parameter logic [SEG_W-1:0]  BLANK_SEG = '0
) (
  input  logic                       CLOCK_50,
  input  logic                       RESET_N,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [SEG_W-1:0]           wr_data,
  input  logic                       len_we,
  input  logic [$clog2(DEPTH):0]     len_in,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       pause,
  input  logic                       step,
  output logic [SEG_W-1:0]           hex5,
  output logic [SEG_W-1:0]           hex4,
  output logic [SEG_W-1:0]           hex3,
  output logic [SEG_W-1:0]           hex2,
  output logic [SEG_W-1:0]           hex1,
  output logic [SEG_W-1:0]           hex0,
  output logic                       running,
  output logic                       wrap
);

  localparam int LW = $clog2(DEPTH);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] c_TERM      = PW'(TICK_DIV - 1);
  localparam logic [LW:0]   c_DEPTH     = (LW+1)'(DEPTH);
  localparam logic [LW:0]   c_LEN_ONE   = (LW+1)'(1);
  localparam logic [LW-1:0] c_POS_ONE   = LW'(1);
  localparam logic [PW-1:0] c_PRESC_ONE = PW'(1);

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t           r_state;
  logic [LW:0]      r_msg_len;
  logic [LW-1:0]    r_pos;
  logic [PW-1:0]    r_presc;
  logic             r_adv_wrap;
  logic             r_running;
  logic             r_wrap;
  logic [SEG_W-1:0] r_mem [DEPTH];
  logic [SEG_W-1:0] r_hex [6];

  logic [LW:0]      w_len_sat;
  logic             w_len_zero;
  logic [LW:0]      w_len_m1;
  logic             w_last;
  logic [LW-1:0]    w_pos_next;
  logic [SEG_W-1:0] w_win [6];

  assign w_len_sat  = (len_in > c_DEPTH) ? c_DEPTH : len_in;
  assign w_len_zero = (w_len_sat == '0);
  assign w_len_m1   = r_msg_len - c_LEN_ONE;
  assign w_last     = ({1'b0, r_pos} == w_len_m1);
  assign w_pos_next = w_last ? '0 : (r_pos + c_POS_ONE);

  // Step through the window one slot at a time, wrapping at msg_len rather
  // than at DEPTH, so short messages repeat their characters across digits.
  function automatic logic [LW-1:0] f_adv(input logic [LW-1:0] p,
                                          input logic [LW:0]   lm1);
    return ({1'b0, p} == lm1) ? '0 : (p + c_POS_ONE);
  endfunction

  always_comb begin
    logic [LW-1:0] v;
    v = r_pos;
    for (int d = 0; d < 6; d++) begin
      w_win[d] = r_mem[v];
      v        = f_adv(v, w_len_m1);
    end
  end

  // Message buffer: written in every state, never reset.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // Control: stop > len_we(0) > start > len_we(nonzero) > tick/step.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= ST_BLANK;
      r_msg_len  <= '0;
      r_pos      <= '0;
      r_presc    <= '0;
      r_adv_wrap <= 1'b0;
    end else begin
      r_adv_wrap <= 1'b0;
      if (len_we) r_msg_len <= w_len_sat;

      if (stop || (len_we && w_len_zero)) begin
        r_state <= ST_BLANK;
        r_pos   <= '0;
        r_presc <= '0;
      end else if (start && (r_state != ST_BLANK || r_msg_len != '0)) begin
        if (r_state == ST_BLANK) r_state <= ST_RUN;
        r_pos   <= '0;
        r_presc <= '0;
      end else if (len_we && r_state != ST_BLANK) begin
        r_pos   <= '0;
        r_presc <= '0;
      end else begin
        case (r_state)
          ST_RUN: begin
            if (pause) begin
              r_state <= ST_PAUSE;
            end else if (r_presc == c_TERM) begin
              r_presc    <= '0;
              r_pos      <= w_pos_next;
              r_adv_wrap <= w_last;
            end else begin
              r_presc <= r_presc + c_PRESC_ONE;
            end
          end
          ST_PAUSE: begin
            if (step) begin
              r_pos      <= w_pos_next;
              r_adv_wrap <= w_last;
            end
            // Prescaler keeps its held value so the interrupted period
            // finishes once running resumes.
            if (!pause) r_state <= ST_RUN;
          end
          default: ;
        endcase
      end
    end
  end

  // Output stage: everything lags the control registers by one cycle, so
  // wrap lines up with the first cycle the digits show position 0.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_running <= 1'b0;
      r_wrap    <= 1'b0;
      for (int d = 0; d < 6; d++) r_hex[d] <= BLANK_SEG;
    end else begin
      r_running <= (r_state == ST_RUN);
      r_wrap    <= r_adv_wrap;
      for (int d = 0; d < 6; d++)
        r_hex[d] <= (r_state == ST_BLANK) ? BLANK_SEG : w_win[d];
    end
  end

  assign hex5    = r_hex[0];
  assign hex4    = r_hex[1];
  assign hex3    = r_hex[2];
  assign hex2    = r_hex[3];
  assign hex1    = r_hex[4];
  assign hex0    = r_hex[5];
  assign running = r_running;
  assign wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_hex_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_scroll_ctrl
// Purpose  : Scoreboard bench for hex_scroll_ctrl. Stimulus queues expected
//            digit/status values tagged with the cycle they must appear on;
//            a monitor on the falling edge pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_scroll_ctrl;

  localparam logic [6:0] A   = 7'h0A;
  localparam logic [6:0] B   = 7'h0B;
  localparam logic [6:0] C   = 7'h0C;
  localparam logic [6:0] X55 = 7'h55;
  localparam logic [41:0] BLANK6 = 42'd0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [6:0] wr_data = '0;
  logic       len_we = 1'b0;
  logic [4:0] len_in = '0;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, step = 1'b0;
  logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;
  logic       running, wrap;

  always #5 clk = ~clk;

  hex_scroll_ctrl #(
    .DEPTH(16), .SEG_W(7), .TICK_DIV(4), .BLANK_SEG(7'b0000000)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len_we(len_we), .len_in(len_in),
    .start(start), .stop(stop), .pause(pause), .step(step),
    .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .running(running), .wrap(wrap)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [41:0] hexv;
    logic        run;
    logic        wr;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [6:0] mdl [16];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [41:0] pk(input logic [6:0] a, b, c, d, e, f);
    return {a, b, c, d, e, f};
  endfunction

  // Reference window with true modulo over the model buffer.
  function automatic logic [41:0] win(input int p, input int len);
    logic [41:0] r;
    r = '0;
    for (int d = 0; d < 6; d++) r[41-7*d -: 7] = mdl[(p + d) % len];
    return r;
  endfunction

  task automatic push(input int c, input string n, input logic [41:0] h,
                      input logic r, input logic w);
    exp_t e;
    int   i;
    e.cyc = c; e.name = n; e.hexv = h; e.run = r; e.wr = w;
    i = 0;
    while (i < q.size() && q[i].cyc <= c) i++;
    q.insert(i, e);
  endtask

  // Monitor: outputs only change on the rising edge (or async reset), so
  // the falling edge is a stable sample point.
  exp_t        mon_e;
  logic [41:0] mon_act;
  always @(negedge clk) begin
    mon_act = {hex5, hex4, hex3, hex2, hex1, hex0};
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      checks++;
      if (mon_e.cyc != cyc || mon_act !== mon_e.hexv ||
          running !== mon_e.run || wrap !== mon_e.wr) begin
        failures++;
        $display("FAIL %s cyc=%0d: got hex=%h running=%b wrap=%b, required hex=%h running=%b wrap=%b at cyc %0d",
                 mon_e.name, cyc, mon_act, running, wrap,
                 mon_e.hexv, mon_e.run, mon_e.wr, mon_e.cyc);
      end
    end
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [6:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d; mdl[a] = d;
    nclk(1);
    wr_en = 1'b0;
  endtask

  task automatic setlen(input logic [4:0] v);
    len_we = 1'b1; len_in = v;
    nclk(1);
    len_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    nclk(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    nclk(1);
    stop = 1'b0;
  endtask

  initial begin
    int n0;
    int m;

    // Reset state
    nclk(2);
    push(cyc + 1, "reset_state", BLANK6, 1'b0, 1'b0);
    nclk(2);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) wr(4'(i), 7'(i + 1));
    setlen(5'd8);

    // Basic scroll, tick timing and wrap at len 8
    n0 = cyc;
    push(n0 + 1, "start_blank_latency", BLANK6, 1'b0, 1'b0);
    push(n0 + 2, "first_window", pk(7'h1, 7'h2, 7'h3, 7'h4, 7'h5, 7'h6), 1'b1, 1'b0);
    push(n0 + 6, "after_one_tick", pk(7'h2, 7'h3, 7'h4, 7'h5, 7'h6, 7'h7), 1'b1, 1'b0);
    push(n0 + 26, "tick6_window", pk(7'h7, 7'h8, 7'h1, 7'h2, 7'h3, 7'h4), 1'b1, 1'b0);
    push(n0 + 34, "wrap_window", pk(7'h1, 7'h2, 7'h3, 7'h4, 7'h5, 7'h6), 1'b1, 1'b1);
    for (int c = n0 + 3; c <= n0 + 37; c++)
      push(c, "len8_sweep", win(((c - n0 - 2) / 4) % 8, 8), 1'b1, (c == n0 + 34));
    pulse_start();
    nclk(36);

    // Stop, short message (len 3), then len 1 mid-run
    n0 = cyc;
    push(n0 + 2, "stop_blank", BLANK6, 1'b0, 1'b0);
    pulse_stop();
    wr(4'd0, A); wr(4'd1, B); wr(4'd2, C);
    setlen(5'd3);
    n0 = cyc;
    push(n0 + 2, "len3_window", pk(A, B, C, A, B, C), 1'b1, 1'b0);
    push(n0 + 6, "len3_tick", pk(B, C, A, B, C, A), 1'b1, 1'b0);
    pulse_start();
    nclk(6);
    m = cyc;
    push(m + 2, "len1_window", pk(A, A, A, A, A, A), 1'b1, 1'b0);
    push(m + 5, "len1_no_wrap_yet", pk(A, A, A, A, A, A), 1'b1, 1'b0);
    push(m + 6, "len1_wrap", pk(A, A, A, A, A, A), 1'b1, 1'b1);
    setlen(5'd1);
    nclk(6);

    // Pause, single step, resume with held prescaler
    pulse_stop();
    setlen(5'd8);
    n0 = cyc;
    push(n0 + 2, "pause_pos0", pk(A, B, C, 7'h4, 7'h5, 7'h6), 1'b1, 1'b0);
    push(n0 + 9, "paused", pk(B, C, 7'h4, 7'h5, 7'h6, 7'h7), 1'b0, 1'b0);
    push(n0 + 12, "paused_frozen", pk(B, C, 7'h4, 7'h5, 7'h6, 7'h7), 1'b0, 1'b0);
    push(n0 + 14, "step1", pk(C, 7'h4, 7'h5, 7'h6, 7'h7, 7'h8), 1'b0, 1'b0);
    push(n0 + 16, "step2", pk(7'h4, 7'h5, 7'h6, 7'h7, 7'h8, A), 1'b0, 1'b0);
    push(n0 + 19, "resumed", pk(7'h4, 7'h5, 7'h6, 7'h7, 7'h8, A), 1'b1, 1'b0);
    push(n0 + 20, "resume_held_presc", pk(7'h4, 7'h5, 7'h6, 7'h7, 7'h8, A), 1'b1, 1'b0);
    push(n0 + 21, "resume_advance", pk(7'h5, 7'h6, 7'h7, 7'h8, A, B), 1'b1, 1'b0);
    pulse_start();
    nclk(6);
    pause = 1'b1;
    nclk(5);
    step = 1'b1; nclk(1); step = 1'b0; nclk(1);
    step = 1'b1; nclk(1); step = 1'b0; nclk(2);
    pause = 1'b0;
    nclk(5);

    // start+stop same cycle, then start with len 0
    n0 = cyc;
    push(n0 + 2, "start_stop_same_cycle", BLANK6, 1'b0, 1'b0);
    push(n0 + 5, "start_len0_ignored", BLANK6, 1'b0, 1'b0);
    push(n0 + 6, "start_len0_stays", BLANK6, 1'b0, 1'b0);
    start = 1'b1; stop = 1'b1;
    nclk(1);
    start = 1'b0; stop = 1'b0;
    setlen(5'd0);
    pulse_start();
    nclk(4);

    // Write mem[pos] while running, then saturating length load
    setlen(5'd8);
    n0 = cyc;
    push(n0 + 2, "pre_write", pk(A, B, C, 7'h4, 7'h5, 7'h6), 1'b1, 1'b0);
    push(n0 + 3, "pre_write_hold", pk(A, B, C, 7'h4, 7'h5, 7'h6), 1'b1, 1'b0);
    push(n0 + 4, "write_visible", pk(X55, B, C, 7'h4, 7'h5, 7'h6), 1'b1, 1'b0);
    pulse_start();
    nclk(1);
    wr(4'd0, X55);
    nclk(2);
    m = cyc;
    push(m + 2, "len_sat_pos0", pk(X55, B, C, 7'h4, 7'h5, 7'h6), 1'b1, 1'b0);
    push(m + 62, "len_sat_pos15", pk(7'h10, X55, B, C, 7'h4, 7'h5), 1'b1, 1'b0);
    push(m + 65, "len_sat_no_early_wrap", pk(7'h10, X55, B, C, 7'h4, 7'h5), 1'b1, 1'b0);
    push(m + 66, "len_sat_wrap16", pk(X55, B, C, 7'h4, 7'h5, 7'h6), 1'b1, 1'b1);
    setlen(5'd20);
    nclk(66);

    // Asynchronous reset mid-run: checked before the next rising edge
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    push(cyc, "async_reset", BLANK6, 1'b0, 1'b0);
    #1;
    checks++;
    if ({hex5, hex4, hex3, hex2, hex1, hex0} !== BLANK6 ||
        running !== 1'b0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_immediate: got hex=%h running=%b wrap=%b",
               {hex5, hex4, hex3, hex2, hex1, hex0}, running, wrap);
    end
    nclk(2);
    push(cyc + 1, "reset_hold", BLANK6, 1'b0, 1'b0);
    nclk(2);
    rst_n = 1'b1;

    for (int i = 0; i < 100 && q.size() > 0; i++) nclk(1);
    nclk(1);
    checks++;
    if ({hex5, hex4, hex3, hex2, hex1, hex0} !== BLANK6 ||
        running !== 1'b0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_blank: got hex=%h running=%b wrap=%b",
               {hex5, hex4, hex3, hex2, hex1, hex0}, running, wrap);
    end
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: never compared, required at cyc %0d (now %0d)",
               mon_e.name, mon_e.cyc, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
